avalon_pio_out: RTL
===================

Name: avalon_pio_out

Overview:
- Avalon-MM write/read slave that drives a 32-bit output port (LEDs, game-state flags, audio-enable lines) from the Nios II.
- Output-side counterpart of the button input PIO: same register-window style, same registered readdata.
- Adds atomic bit set/clear and a hardware one-shot pulse, so software can strobe a line for a fixed time without polling.

Parameters:
- WIDTH, 32, output port width in bits; valid range 1..32. Unused upper readdata bits read 0.
- RESET_VALUE, 0, value loaded into the data register on reset.
- PULSE_CYCLES, 50000000, duration of a one-shot pulse in clk cycles; must be >= 1. Bench uses 4.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- address  input  3  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; qualified by chipselect.
- writedata  input  32  write data; bits above WIDTH are ignored.
- readdata  output  32  registered read data.
- out_port  output  WIDTH  driven output, equal to data_reg | pulse_mask.

Behaviour:
- Reset (sampled at a clk edge with reset=1):
  - data_reg=RESET_VALUE, pulse_mask=0, pulse_cnt=0, readdata=0.
  - out_port=RESET_VALUE after that edge.
  - Reset mid-pulse aborts the pulse immediately.
- A write occurs on any edge where chipselect=1 and write_n=0. It takes effect at that edge, and out_port reflects it in the following cycle (1-cycle latency).
- Register map:
  - 0 DATA (RW): data_reg <= writedata.
  - 1 OUTSET (W): data_reg <= data_reg | writedata.
  - 2 OUTCLEAR (W): data_reg <= data_reg & ~writedata.
  - 3 PULSE (RW): pulse_mask <= writedata and pulse_cnt <= PULSE_CYCLES-1. A write of 0 cancels the active pulse, with pulse_cnt <= 0.
  - 4 STATUS (RO): bit0 = busy (pulse_mask != 0); bits 31:1 read 0.
  - 5-7: writes ignored; reads return 0.
  - Reads of OUTSET and OUTCLEAR return 0.
- Pulse state machine:
  - IDLE (pulse_mask=0) -> ACTIVE on a nonzero PULSE write.
  - In ACTIVE, pulse_cnt decrements by 1 each edge while nonzero.
  - At an edge with pulse_cnt=0 and no PULSE write, pulse_mask <= 0 and the FSM returns to IDLE.
  - Net effect: pulse bits are high for exactly PULSE_CYCLES cycles.
- Boundary rules:
  - A PULSE write while ACTIVE replaces the mask and restarts the count. This also applies on the expiry edge: the write wins.
  - For PULSE_CYCLES=1, the pulse is high for 1 cycle.
  - A bit set in both data_reg and pulse_mask stays high after the pulse expires. OUTCLEAR does not affect pulse_mask.
- readdata:
  - readdata <= mux(address) on every edge, independent of read strobe and of chipselect; no side effects.
  - A read issued the cycle after a write returns the new value.
- Counter width is ceil(log2(PULSE_CYCLES)), minimum 1. There is no wrap: the counter stops at 0.

Test Plan:
- Reset with RESET_VALUE=0x0000_00A5 -> out_port=0xA5, readdata=0. Read address 0 -> 0xA5 one cycle later.
- Write DATA=0x0F, then OUTSET=0xF0, then OUTCLEAR=0x03 -> out_port sequence 0x0F, 0xFF, 0xFC, each one cycle after its write edge. Read of address 1 -> 0.
- With PULSE_CYCLES=4 and DATA=0: write PULSE=0x100 -> out_port=0x100 for exactly 4 cycles, then 0. STATUS reads 1 during the pulse and 0 after.
- Rewrite PULSE=0x200 on the expiry edge of a 0x100 pulse -> out_port goes 0x100 to 0x200 with no gap, and 0x200 holds 4 cycles. Write PULSE=0 mid-pulse -> out_port=0 the next cycle.
- Reset asserted 2 cycles into a pulse with DATA=0x1 -> out_port=RESET_VALUE, STATUS=0. Write to address 6 -> no register change.
- chipselect=0 with write_n=0 -> no register change.

Source files
------------

// File: rtl/avalon_pio_out.sv
// Avalon-MM output PIO: data register with atomic set/clear, plus a hardware
// one-shot pulse mask that is OR-ed onto the output for PULSE_CYCLES cycles.
module avalon_pio_out #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VALUE  = 32'h0,
  parameter int unsigned PULSE_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int unsigned CntW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  // Loaded value counts the edges still to go before expiry, so the mask is
  // high for exactly PULSE_CYCLES cycles.
  localparam logic [CntW-1:0]  CntLoad   = CntW'(PULSE_CYCLES - 1);
  localparam logic [WIDTH-1:0] DataReset = RESET_VALUE[WIDTH-1:0];

  localparam logic [2:0] AddrData     = 3'd0;
  localparam logic [2:0] AddrOutSet   = 3'd1;
  localparam logic [2:0] AddrOutClear = 3'd2;
  localparam logic [2:0] AddrPulse    = 3'd3;
  localparam logic [2:0] AddrStatus   = 3'd4;

  typedef enum logic [0:0] {StIdle, StActive} pulse_state_e;

  pulse_state_e     state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [31:0]      readdata_d;

  logic             wr_en;
  logic             pulse_wr;
  logic [WIDTH-1:0] wdata;

  assign wr_en    = chipselect & ~write_n;
  assign pulse_wr = wr_en && (address == AddrPulse);
  assign wdata    = writedata[WIDTH-1:0];

  // Data register next state: plain write, atomic set and atomic clear.
  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      case (address)
        AddrData:     data_d = wdata;
        AddrOutSet:   data_d = data_q | wdata;
        AddrOutClear: data_d = data_q & ~wdata;
        default:      data_d = data_q;
      endcase
    end
  end

  // Pulse FSM: a PULSE write always wins over countdown or expiry.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pulse_wr && (wdata != '0)) begin
          mask_d  = wdata;
          cnt_d   = CntLoad;
          state_d = StActive;
        end
      end
      StActive: begin
        if (pulse_wr) begin
          if (wdata != '0) begin
            mask_d = wdata;
            cnt_d  = CntLoad;
          end else begin
            mask_d  = '0;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          mask_d  = '0;
          state_d = StIdle;
        end
      end
      default: begin
        mask_d  = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Read mux, sampled every edge regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address)
      AddrData:   readdata_d[WIDTH-1:0] = data_q;
      AddrPulse:  readdata_d[WIDTH-1:0] = mask_q;
      AddrStatus: readdata_d[0]         = (mask_q != '0);
      default:    readdata_d            = '0;
    endcase
  end

  // State registers with synchronous reset; reset also aborts any pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      data_q   <= DataReset;
      mask_q   <= '0;
      cnt_q    <= '0;
      readdata <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      readdata <= readdata_d;
    end
  end

  assign out_port = data_q | mask_q;

endmodule
